// File: rtl/act_lut_pipe_if.sv
// Sample stream and table-config bus for act_lut_pipe.
interface act_lut_pipe_if #(
  parameter int DW = 21,
  parameter int AW = 6
);
  logic                 in_valid;
  logic signed [DW-1:0] in;
  logic                 bypass;
  logic                 shift_overf;
  logic                 out_valid;
  logic signed [DW-1:0] out;
  logic                 cfg_we;
  logic                 cfg_sel;
  logic [AW-1:0]        cfg_addr;
  logic [DW-1:0]        cfg_wdata;
  logic                 cfg_err;

  modport master (
    output in_valid, in, bypass, shift_overf,
    output cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    input  out_valid, out, cfg_err
  );

  modport slave (
    input  in_valid, in, bypass, shift_overf,
    input  cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    output out_valid, out, cfg_err
  );
endinterface

// File: rtl/act_lut_pipe.sv
// Piecewise-constant activation: pipelined binary search over thresholds.
// Optional saturating overflow counter: define ACT_LUT_OVF_CNT_EN.
module act_lut_pipe #(
  parameter int DW = 21,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  act_lut_pipe_if.slave bus,
  output logic [15:0]   ovf_cnt
);
  localparam int DEPTH = 1 << AW;
  localparam logic signed [DW-1:0] THR_RST =
    {1'b0, {(DW-1){1'b1}}};

  logic signed [DW-1:0] thr [DEPTH];
  logic [DW-1:0]        val [DEPTH];

  logic [AW-1:0]        st_v;
  logic [AW-1:0]        st_z;
  logic signed [DW-1:0] st_d [AW];
  logic [AW-1:0]        st_i [AW];
  logic [AW-1:0]        nxt_i [AW];
  logic [AW-1:0]        cand;

  logic                 busy;
  logic                 cfg_ok;
  logic                 cfg_err_q;
  logic                 out_v_q;
  logic signed [DW-1:0] out_q;

  assign busy   = |st_v;
  assign cfg_ok = bus.cfg_we & ~busy;

  assign bus.out_valid = out_v_q;
  assign bus.out       = out_q;
  assign bus.cfg_err   = cfg_err_q;

  // Layer k resolves index bit AW-1-k; the last one feeds the value mux.
  always_comb begin
    cand = '0;
    for (int k = 0; k < AW; k++) begin
      cand     = st_i[k] | (AW'(1) << (AW - 1 - k));
      nxt_i[k] = (st_d[k] >= thr[cand]) ? cand : st_i[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_v    <= '0;
      st_z    <= '0;
      out_v_q <= 1'b0;
      out_q   <= '0;
      for (int k = 0; k < AW; k++) begin
        st_d[k] <= '0;
        st_i[k] <= '0;
      end
    end else if (en) begin
      st_v[0] <= bus.in_valid;
      st_z[0] <= bus.bypass | bus.shift_overf;
      st_d[0] <= bus.in;
      st_i[0] <= '0;
      for (int k = 1; k < AW; k++) begin
        st_v[k] <= st_v[k-1];
        st_z[k] <= st_z[k-1];
        st_d[k] <= st_d[k-1];
        st_i[k] <= nxt_i[k-1];
      end
      out_v_q <= st_v[AW-1];
      if (st_v[AW-1])
        out_q <= st_z[AW-1] ? '0 : val[nxt_i[AW-1]];
    end
  end

  // Table writes only land while the pipe is empty, so no lookup sees a torn table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err_q <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        thr[j] <= THR_RST;
        val[j] <= '0;
      end
    end else begin
      cfg_err_q <= bus.cfg_we & busy;
      if (cfg_ok) begin
        if (bus.cfg_sel)
          val[bus.cfg_addr] <= bus.cfg_wdata;
        else if (bus.cfg_addr != '0)
          thr[bus.cfg_addr] <= bus.cfg_wdata;
      end
    end
  end

`ifdef ACT_LUT_OVF_CNT_EN
  logic        acc;
  logic [15:0] ovf_q;

  assign acc     = en & bus.in_valid;
  assign ovf_cnt = ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf_q <= '0;
    else if (acc && bus.shift_overf && ovf_q != 16'hFFFF)
      ovf_q <= ovf_q + 16'd1;
  end
`else
  assign ovf_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_act_lut_pipe.sv
// Directed bench for act_lut_pipe (DW=21, AW=6).
module tb_act_lut_pipe;
  localparam int DW = 21;
  localparam int AW = 6;

`ifdef ACT_LUT_OVF_CNT_EN
  localparam logic [15:0] OVF_EXP = 16'd1;
`else
  localparam logic [15:0] OVF_EXP = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en;
  logic [15:0] ovf_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  act_lut_pipe_if #(.DW(DW), .AW(AW)) bus ();

  act_lut_pipe #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .bus     (bus),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic sel, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic accept(input logic [DW-1:0] x, input logic byp,
                        input logic ovf);
    bus.in_valid    = 1'b1;
    bus.in          = x;
    bus.bypass      = byp;
    bus.shift_overf = ovf;
    tick();
    bus.in_valid    = 1'b0;
    bus.bypass      = 1'b0;
    bus.shift_overf = 1'b0;
  endtask

  // Called just after acceptance; result expected after n more edges.
  task automatic wait_result(input int n, input logic [DW-1:0] exp,
                             input string nm);
    logic early;
    early = 1'b0;
    for (int i = 1; i < n; i++) begin
      tick();
      if (bus.out_valid) early = 1'b1;
    end
    vectors++;
    if (early !== 1'b0) begin
      miscompares++;
      $display("FAIL %s early_valid got=%b want=0", nm, early);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== exp) begin
      miscompares++;
      $display("FAIL %s got v=%b out=%h want v=1 out=%h",
               nm, bus.out_valid, bus.out, exp);
    end
  endtask

  task automatic lookup(input logic [DW-1:0] x, input logic [DW-1:0] exp,
                        input string nm);
    accept(x, 1'b0, 1'b0);
    wait_result(6, exp, nm);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out !== '0 ||
        bus.cfg_err !== 1'b0 || ovf_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b out=%h err=%b cnt=%h want 0",
               bus.out_valid, bus.out, bus.cfg_err, ovf_cnt);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load_table();
    for (int j = 1; j < 64; j++)
      write_cfg(1'b0, AW'(j), DW'((j - 32) * 32'h400));
    for (int k = 0; k < 64; k++)
      write_cfg(1'b1, AW'(k), DW'(k * 32'h147));
  endtask

  task automatic test_lookup();
    lookup(21'h000000, 21'h028E0, "in_zero");
    lookup(21'h1FFFFF, 21'h02799, "in_minus1");
    lookup(21'h100000, 21'h00000, "in_min");
    lookup(21'h0FFFFF, 21'h05079, "in_max");
    lookup(21'h000400, 21'h02A27, "at_thr33");
    lookup(21'h0003FF, 21'h028E0, "below_thr33");
    lookup(21'h1F8400, 21'h00147, "at_thr1");
    lookup(21'h1F83FF, 21'h00000, "below_thr1");
  endtask

  task automatic test_flags();
    accept(21'h000000, 1'b0, 1'b1);
    wait_result(6, 21'h0, "shift_overf");
    vectors++;
    if (ovf_cnt !== OVF_EXP) begin
      miscompares++;
      $display("FAIL ovf_cnt got=%h want=%h", ovf_cnt, OVF_EXP);
    end
    accept(21'h000000, 1'b1, 1'b0);
    wait_result(6, 21'h0, "bypass");
    vectors++;
    if (ovf_cnt !== OVF_EXP) begin
      miscompares++;
      $display("FAIL ovf_cnt_bypass got=%h want=%h", ovf_cnt, OVF_EXP);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] xs [4];
    logic [DW-1:0] ex [4];
    xs = '{21'h000000, 21'h1FFFFF, 21'h0FFFFF, 21'h000400};
    ex = '{21'h028E0, 21'h02799, 21'h05079, 21'h02A27};
    for (int i = 0; i < 4; i++) accept(xs[i], 1'b0, 1'b0);
    tick();
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_early got v=%b want=0", bus.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out !== ex[i]) begin
        miscompares++;
        $display("FAIL b2b_%0d got v=%b out=%h want v=1 out=%h",
                 i, bus.out_valid, bus.out, ex[i]);
      end
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_tail got v=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_cfg();
    accept(21'h000000, 1'b0, 1'b0);
    write_cfg(1'b1, 6'd32, 21'h12345);
    vectors++;
    if (bus.cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_err_pulse got=%b want=1", bus.cfg_err);
    end
    tick();
    vectors++;
    if (bus.cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_clear got=%b want=0", bus.cfg_err);
    end
    wait_result(4, 21'h028E0, "cfg_inflight");
    lookup(21'h000000, 21'h028E0, "cfg_readback");
    write_cfg(1'b0, 6'd0, 21'h000000);
    vectors++;
    if (bus.cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_thr0_err got=%b want=0", bus.cfg_err);
    end
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = 1'b1;
    bus.cfg_addr  = 6'd32;
    bus.cfg_wdata = 21'h11111;
    accept(21'h000000, 1'b0, 1'b0);
    bus.cfg_we    = 1'b0;
    wait_result(6, 21'h11111, "cfg_same_edge");
    write_cfg(1'b1, 6'd32, 21'h028E0);
    lookup(21'h000000, 21'h028E0, "cfg_restore");
  endtask

  task automatic test_stall();
    accept(21'h000400, 1'b0, 1'b0);
    tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    tick();
    en = 1'b1;
    wait_result(4, 21'h02A27, "stall_3");
    en = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== 21'h02A27) begin
      miscompares++;
      $display("FAIL stall_hold got v=%b out=%h want v=1 out=02a27",
               bus.out_valid, bus.out);
    end
    en = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out !== 21'h02A27) begin
      miscompares++;
      $display("FAIL stall_drop got v=%b out=%h want v=0 out=02a27",
               bus.out_valid, bus.out);
    end
  endtask

  task automatic test_reset_flight();
    logic seen;
    accept(21'h000000, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    #2;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out !== '0 || ovf_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_async got v=%b out=%h cnt=%h want 0",
               bus.out_valid, bus.out, ovf_cnt);
    end
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_flush got v=%b want=0", seen);
    end
    lookup(21'h000000, 21'h0, "rst_table");
  endtask

  initial begin
    en              = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in          = '0;
    bus.bypass      = 1'b0;
    bus.shift_overf = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_sel     = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_wdata   = '0;
    test_reset();
    load_table();
    test_lookup();
    test_flags();
    test_back_to_back();
    test_cfg();
    test_stall();
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
